// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared definitions for the decoder round-robin arbiter: FSM encodings,
// decoder enable codes and the index wrap helper used by the picker.
package decoder_arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Decoder enable as {G1,G2}.
    localparam logic [1:0] ENA_ON  = 2'b10;
    localparam logic [1:0] ENA_OFF = 2'b00;

    localparam int IDX_W = 3;

    function automatic logic [2:0] wrap_idx(input logic [3:0] v, input logic [3:0] n);
        return (v >= n) ? 3'(v - n) : 3'(v);
    endfunction

endpackage

// File: rtl/decoder_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: the search starts one past the last
// winner, so the last winner always has the lowest priority.
module rr_pick
    import decoder_arb_defs::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  iReq,
    input  logic [IDX_W-1:0] iLast,
    output logic [NREQ-1:0]  oWinOh,
    output logic [IDX_W-1:0] oWinIdx,
    output logic             oValid
);

    localparam logic [3:0] N4 = 4'(NREQ);

    logic [7:0]       w_req8;
    logic [7:0]       w_rot;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_off;

    // Rotate the requests to start at last+1, take the first set bit, rotate back.
    always_comb begin
        w_req8            = 8'b0;
        w_req8[NREQ-1:0]  = iReq;
        w_start           = wrap_idx({1'b0, iLast} + 4'd1, N4);
        w_rot             = 8'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_rot[i] = w_req8[wrap_idx({1'b0, w_start} + 4'(i), N4)];
        end
        w_off = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_off = w_rot[i] ? 3'(i) : w_off;
        end
        oValid  = |w_rot;
        oWinIdx = wrap_idx({1'b0, w_start} + {1'b0, w_off}, N4);
        oWinOh  = '0;
        for (int i = 0; i < NREQ; i++) begin
            oWinOh[i] = oValid && (oWinIdx == 3'(i));
        end
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Shares one 3-to-8 decoder between NREQ requesters: round-robin grant,
// hold the selected line for the requested length, then a dead cycle.
module decoder_rr_arbiter
    import decoder_arb_defs::*;
#(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic [NREQ-1:0]       iReq,
    input  logic [3*NREQ-1:0]     iSel,
    input  logic [LEN_W*NREQ-1:0] iLen,
    output logic [NREQ-1:0]       oGnt,
    output logic [2:0]            oDecData,
    output logic [1:0]            oDecEna,
    output logic                  oBusy,
    output logic                  oDone
);

    state_t           r_state;
    logic [2:0]       r_sel;
    logic [LEN_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_last;
    logic [NREQ-1:0]  r_gnt;
    logic [1:0]       r_ena;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [2:0]       w_sel_nxt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] w_last_nxt;
    logic [NREQ-1:0]  w_gnt_nxt;
    logic [1:0]       w_ena_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    logic [NREQ-1:0]  w_win_oh;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_valid;
    logic [2:0]       w_pick_sel;
    logic [LEN_W-1:0] w_pick_raw;
    logic [LEN_W-1:0] w_pick_len;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .iReq    (iReq),
        .iLast   (r_last),
        .oWinOh  (w_win_oh),
        .oWinIdx (w_win_idx),
        .oValid  (w_valid)
    );

    // Route the winner's select and length slices; a zero length means one cycle.
    always_comb begin
        w_pick_sel = 3'd0;
        w_pick_raw = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_pick_sel = w_win_oh[i] ? iSel[3*i +: 3]         : w_pick_sel;
            w_pick_raw = w_win_oh[i] ? iLen[LEN_W*i +: LEN_W] : w_pick_raw;
        end
        w_pick_len = (w_pick_raw == '0) ? LEN_W'(1) : w_pick_raw;
    end

    // Next-state and next-output logic; outputs are computed one edge ahead so they can be registered.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_gnt_nxt   = '0;
        w_ena_nxt   = ENA_OFF;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_state_nxt = ST_HOLD;
                    w_sel_nxt   = w_pick_sel;
                    w_cnt_nxt   = w_pick_len;
                    w_last_nxt  = w_win_idx;
                    w_gnt_nxt   = w_win_oh;
                    w_ena_nxt   = ENA_ON;
                    w_done_nxt  = (w_pick_len == LEN_W'(1));
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                w_cnt_nxt = r_cnt - LEN_W'(1);
                if (r_cnt == LEN_W'(1)) begin
                    w_state_nxt = ST_GAP;
                end else begin
                    w_state_nxt = ST_HOLD;
                    w_ena_nxt   = ENA_ON;
                    w_done_nxt  = (r_cnt == LEN_W'(2));
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State, datapath and output registers; reset drops the decoder enable at once.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= 3'd0;
            r_cnt   <= '0;
            r_last  <= 3'(NREQ - 1);
            r_gnt   <= '0;
            r_ena   <= ENA_OFF;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ena   <= w_ena_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign oGnt     = r_gnt;
    assign oDecData = r_sel;
    assign oDecEna  = r_ena;
    assign oBusy    = r_busy;
    assign oDone    = r_done;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter: directed scenarios plus random
// traffic, compared against a grant-window model of the arbiter.
module tb_decoder_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int LEN_W = 4;

    logic                  iClk = 1'b0;
    logic                  iRst_n;
    logic [NREQ-1:0]       iReq;
    logic [3*NREQ-1:0]     iSel;
    logic [LEN_W*NREQ-1:0] iLen;
    logic [NREQ-1:0]       oGnt;
    logic [2:0]            oDecData;
    logic [1:0]            oDecEna;
    logic                  oBusy;
    logic                  oDone;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: one grant window described by start cycle, length, winner and select.
    int         m_last;
    int         m_free_at;
    int         m_start;
    int         m_len;
    int         m_win;
    logic [2:0] m_sel;

    decoder_rr_arbiter #(
        .NREQ  (NREQ),
        .LEN_W (LEN_W)
    ) dut (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iReq     (iReq),
        .iSel     (iSel),
        .iLen     (iLen),
        .oGnt     (oGnt),
        .oDecData (oDecData),
        .oDecEna  (oDecEna),
        .oBusy    (oBusy),
        .oDone    (oDone)
    );

    always #5 iClk = ~iClk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last    = NREQ - 1;
        m_free_at = 0;
        m_start   = -100;
        m_len     = 1;
        m_win     = 0;
        m_sel     = 3'd0;
    endtask

    // Arbitration happens only at an edge where the block is free again.
    task automatic model_edge();
        bit found;
        int w;
        int lv;
        found = 1'b0;
        w     = 0;
        if (cyc >= m_free_at && iReq != '0) begin
            for (int j = 1; j <= NREQ; j++) begin
                int idx;
                idx = (m_last + j) % NREQ;
                if (iReq[idx] && !found) begin
                    found = 1'b1;
                    w     = idx;
                end
            end
            lv        = int'(iLen[LEN_W*w +: LEN_W]);
            m_len     = (lv == 0) ? 1 : lv;
            m_start   = cyc;
            m_win     = w;
            m_last    = w;
            m_sel     = iSel[3*w +: 3];
            m_free_at = cyc + m_len + 2;
        end
    endtask

    task automatic compare_outputs();
        bit in_hold;
        in_hold = (cyc >= m_start) && (cyc < m_start + m_len);
        check_val("gnt",  32'(oGnt), (cyc == m_start) ? (32'd1 << m_win) : 32'd0);
        check_val("ena",  32'(oDecEna), in_hold ? 32'd2 : 32'd0);
        check_val("data", 32'(oDecData), 32'(m_sel));
        check_val("done", 32'(oDone), (cyc == m_start + m_len - 1) ? 32'd1 : 32'd0);
        check_val("busy", 32'(oBusy), (cyc >= m_start && cyc <= m_start + m_len) ? 32'd1 : 32'd0);
    endtask

    task automatic step(input logic [NREQ-1:0] req, input logic [3*NREQ-1:0] sel,
                        input logic [LEN_W*NREQ-1:0] len);
        @(negedge iClk);
        iReq = req;
        iSel = sel;
        iLen = len;
        @(posedge iClk);
        cyc++;
        model_edge();
        #1;
        compare_outputs();
    endtask

    // Asserts reset right now (mid-cycle) with all requests high; outputs must clear immediately.
    task automatic do_reset();
        iRst_n = 1'b0;
        iReq   = '1;
        #1;
        check_val("rst_async_ena",  32'(oDecEna), 32'd0);
        check_val("rst_async_busy", 32'(oBusy), 32'd0);
        repeat (3) begin
            @(posedge iClk);
            #1;
            check_val("rst_gnt",  32'(oGnt), 32'd0);
            check_val("rst_data", 32'(oDecData), 32'd0);
            check_val("rst_ena",  32'(oDecEna), 32'd0);
            check_val("rst_done", 32'(oDone), 32'd0);
        end
        #1;
        iRst_n = 1'b1;
        model_reset();
    endtask

    logic [NREQ-1:0]       r_req;
    logic [LEN_W*NREQ-1:0] r_len;
    logic [NREQ-1:0]       seen;
    logic [NREQ-1:0]       exp_seq [5];
    int                    gi;

    initial begin
        iRst_n = 1'b1;
        iReq   = '0;
        iSel   = '0;
        iLen   = '0;
        model_reset();
        #1;

        // Reset with all requests high, then requester 0 wins first.
        do_reset();
        step(4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 16'h1111);
        check_val("first_after_rst", 32'(oGnt), 32'd1);
        repeat (3) step(4'b0000, '0, '0);

        // Single request: line 5 for 3 cycles, then two dead cycles.
        do_reset();
        step(4'b0001, {3'd0, 3'd0, 3'd0, 3'd5}, 16'h0003);
        check_val("single_gnt",  32'(oGnt), 32'd1);
        check_val("single_data", 32'(oDecData), 32'd5);
        repeat (5) step(4'b0000, '0, '0);

        // Full contention, all lengths 1: grants rotate every 3 cycles.
        do_reset();
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        gi = 0;
        for (int i = 0; i < 15; i++) begin
            step(4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 16'h1111);
            if (oGnt != '0) begin
                if (gi < 5) check_val("contention_order", 32'(oGnt), 32'(exp_seq[gi]));
                gi++;
            end
        end
        check_val("contention_count", 32'(gi), 32'd5);
        repeat (3) step(4'b0000, '0, '0);

        // Zero length behaves as one cycle with done in the same cycle.
        do_reset();
        step(4'b0001, {3'd0, 3'd0, 3'd0, 3'd6}, 16'h0000);
        check_val("zero_len_ena",  32'(oDecEna), 32'd2);
        check_val("zero_len_done", 32'(oDone), 32'd1);
        repeat (3) step(4'b0000, '0, '0);

        // Requester 2 withdraws during requester 1's hold; requester 3 gets the next grant.
        do_reset();
        step(4'b1110, {3'd7, 3'd6, 3'd2, 3'd0}, 16'h1123);
        check_val("wd_first", 32'(oGnt), 32'd2);
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            step(4'b1000, {3'd7, 3'd6, 3'd2, 3'd0}, 16'h1123);
            if (seen == '0 && oGnt != '0) seen = oGnt;
        end
        check_val("wd_next_gnt", 32'(seen), 32'd8);
        repeat (3) step(4'b0000, '0, '0);

        // Reset in the second cycle of a length-5 hold; the grant is not resumed.
        do_reset();
        step(4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, 16'h0005);
        step(4'b0000, '0, '0);
        check_val("pre_rst_ena", 32'(oDecEna), 32'd2);
        do_reset();
        step(4'b1010, {3'd1, 3'd2, 3'd3, 3'd4}, 16'h2222);
        check_val("post_rst_gnt", 32'(oGnt), 32'd2);
        repeat (4) step(4'b0000, '0, '0);

        // Random traffic including withdrawals, zero and maximum lengths.
        for (int i = 0; i < 400; i++) begin
            r_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r_req = '0;
            for (int k = 0; k < NREQ; k++) begin
                r_len[LEN_W*k +: LEN_W] = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
            end
            step(r_req, 12'($urandom()), r_len);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decoder_rr_arbiter.md
# decoder_rr_arbiter

Round-robin arbiter and sequencer that shares the single 3-to-8 `decoder` between several requesters. Each requester asks for one decoder output line, `iSel`, to be held active for a requested number of cycles, `iLen`. The block grants requesters one at a time and drives the decoder's `iData`/`iEna` inputs for the granted hold period. It inserts a break-before-make dead cycle between grants. It sits between the requesting control logic and the `decoder` instance in the parent module.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `LEN_W`, 4: width of each hold-length field.

Ports:
- `iClk`  in  1  system clock; all state changes on the rising edge.
- `iRst_n`  in  1  asynchronous, active-low reset.
- `iReq`  in  NREQ  request bits; bit i = requester i.
- `iSel`  in  3*NREQ  per-requester line select; slice [3i+2:3i] belongs to requester i.
- `iLen`  in  LEN_W*NREQ  per-requester hold length in cycles; 0 is treated as 1.
- `oGnt`  out  NREQ  one-hot grant pulse, one cycle wide.
- `oDecData`  out  3  to `decoder.iData` (D2..D0).
- `oDecEna`  out  2  to `decoder.iEna` as {G1,G2}; `2'b10` = enabled, `2'b00` = disabled.
- `oBusy`  out  1  high whenever the state is not IDLE.
- `oDone`  out  1  one-cycle pulse on the last HOLD cycle.

## Operation
- States: IDLE, HOLD, GAP, held in a registered 2-bit state.
- IDLE
  - `oDecEna` = 00.
  - If `iReq` != 0 at the edge: choose the winner round-robin, starting from index `last+1` and wrapping at NREQ.
  - Latch the winner's `iSel` slice into the select register and `max(iLen slice,1)` into the counter.
  - Set `last` to the winner, pulse `oGnt[winner]`, go to HOLD.
- HOLD
  - `oDecData` = latched select, `oDecEna` = 10.
  - The counter decrements each edge.
  - When the counter = 1: `oDone` is high this cycle, and the next state is GAP.
- GAP
  - `oDecEna` = 00 for exactly one cycle, then go to IDLE unconditionally.
- `iReq`, `iSel` and `iLen` are sampled only at the IDLE arbitration edge.
  - Changes during HOLD or GAP are ignored.
  - A requester that drops `iReq` before being granted is treated as withdrawn. No state is kept for it.
- A requester must hold `iReq` until it sees `oGnt`.
  - Keeping `iReq` high after the grant counts as a new request.
  - That new request competes normally and receives the lowest priority next round.
- `oDecData` holds its last value while disabled. It has no functional meaning when `oDecEna` = 00.
- All outputs are registered. No combinational path exists from inputs to outputs.
- Reset values:
  - state = IDLE.
  - `oGnt` = 0, `oDecData` = 000, `oDecEna` = 00, `oBusy` = 0, `oDone` = 0.
  - counter = 0.
  - `last` = NREQ-1, so requester 0 has first priority after reset.
- Reset asserted mid-HOLD forces `oDecEna` to 00 immediately (asynchronously). The interrupted grant is not resumed.

## Timing
- A request visible before edge k, with the block in IDLE:
  - `oGnt` high and the first HOLD cycle both occur in cycle k.
  - `oDecEna` = 10 for cycles k through k+L-1, where L = max(len,1).
  - `oDone` is high in cycle k+L-1.
  - GAP occupies cycle k+L; IDLE occupies cycle k+L+1.
- Throughput with continuous requests: one grant every L+2 cycles.
- Outputs are never enabled in two consecutive grant windows without at least two disabled cycles (GAP and IDLE) between them.
- The maximum hold is 2^LEN_W - 1 cycles. The counter is LEN_W bits wide and never wraps.

## Structure
- Shared header `decoder_arb_defs`:
  - state encodings `ST_IDLE`, `ST_HOLD`, `ST_GAP`.
  - `ENA_ON` = 2'b10 and `ENA_OFF` = 2'b00.
- One sub-module, `rr_pick`: combinational.
  - Inputs: `iReq`, `last`.
  - Outputs: one-hot winner and its binary index.
  - Implementation: rotate, find first set bit, rotate back.
- The top level contains the FSM, select register, counter, `last` pointer and output registers.
- The `decoder` itself is instantiated by the parent, not inside this block.

## Test plan
- **Reset:** hold `iRst_n` = 0 with `iReq` = 1111.
  - All outputs stay 0 and `oDecEna` = 00.
  - After release, requester 0 is granted first.
- **Single request:** `iReq` = 0001, sel0 = 101, len0 = 3.
  - One-cycle `oGnt` = 0001.
  - `oDecData` = 101 with `oDecEna` = 10 for exactly 3 cycles; `oDone` on the 3rd.
  - Then 00 for 2 cycles.
- **Full contention:** `iReq` = 1111 held, all len = 1.
  - Grants 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
  - sel values appear in the same order.
- **Zero length:** len = 0.
  - `oDecEna` = 10 for exactly 1 cycle, with `oDone` in that same cycle.
- **Withdrawal:** during requester 1's HOLD, requester 2 drops `iReq` while requester 3 keeps it high.
  - The next grant is 1000.
- **Reset mid-HOLD:** assert `iRst_n` = 0 in the 2nd cycle of a len = 5 hold.
  - `oDecEna` goes to 00 immediately.
  - After release with `iReq` = 1010, the grant is 0010.
